// File: rtl/wb_slot_interconnect.sv
// wb_slot_interconnect: Wishbone fan-out from the management-SoC slave port to NUM_SLAVES
// fixed-size slots, with a per-access timeout watchdog and a status/timeout-record slot.
`default_nettype none

module wb_slot_interconnect #(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          SLOT_BITS  = 12,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [NUM_SLAVES-1:0]    m_cyc_o,
  output logic [NUM_SLAVES-1:0]    m_stb_o,
  output logic                     m_we_o,
  output logic [3:0]               m_sel_o,
  output logic [31:0]              m_dat_o,
  output logic [SLOT_BITS-1:0]     m_adr_o,
  input  logic [32*NUM_SLAVES-1:0] m_dat_i,
  input  logic [NUM_SLAVES-1:0]    m_ack_i
);

  localparam int          IDXW    = $clog2(NUM_SLAVES + 1);
  localparam int          PW      = SLOT_BITS + IDXW;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [IDXW-1:0]         cur_idx;
  logic [15:0]             timer;
  logic [NUM_SLAVES-1:0]   strobe;
  logic [31:0]             req_addr;
  logic [15:0]             timeout_cnt;
  logic [31:0]             last_to_addr;

  logic                    req;
  logic                    prefix_ok;
  logic [IDXW-1:0]         adr_idx;
  logic                    is_core;
  logic                    is_status;
  logic [SLOT_BITS-3:0]    word_off;
  logic [31:0]             status_rdata;
  logic                    status_clear;
  logic                    slave_ack;
  logic [31:0]             slave_dat;

  assign req       = wbs_cyc_i & wbs_stb_i;
  assign prefix_ok = (wbs_adr_i[31:PW] == BASE_ADDR[31:PW]);
  assign adr_idx   = wbs_adr_i[PW-1:SLOT_BITS];
  assign is_core   = prefix_ok && (adr_idx < IDXW'(NUM_SLAVES));
  assign is_status = prefix_ok && (adr_idx == IDXW'(NUM_SLAVES));
  assign word_off  = wbs_adr_i[SLOT_BITS-1:2];

  assign status_clear = is_status && wbs_we_i && wbs_sel_i[0] && wbs_dat_i[0] &&
                        (word_off == (SLOT_BITS-2)'(2));

  assign m_cyc_o = strobe;
  assign m_stb_o = strobe;

  always_comb begin
    status_rdata = 32'h0;
    if (word_off == '0)
      status_rdata = {16'h0, timeout_cnt};
    else if (word_off == (SLOT_BITS-2)'(1))
      status_rdata = last_to_addr;
  end

  // Only the slot owning the current access may ack or supply data.
  always_comb begin
    slave_ack = 1'b0;
    slave_dat = 32'h0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (cur_idx == IDXW'(k)) begin
        slave_ack = m_ack_i[k];
        slave_dat = m_dat_i[32*k +: 32];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  // A host that abandons the cycle takes priority; then ack beats the timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) state_next = is_core ? ACCESS : RESP;
      end
      ACCESS: begin
        if (!wbs_cyc_i)                           state_next = IDLE;
        else if (slave_ack || (timer == TO_LAST)) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= 32'h0;
      strobe       <= '0;
      m_we_o       <= 1'b0;
      m_sel_o      <= 4'h0;
      m_dat_o      <= 32'h0;
      m_adr_o      <= '0;
      cur_idx      <= '0;
      timer        <= 16'h0;
      req_addr     <= 32'h0;
      timeout_cnt  <= 16'h0;
      last_to_addr <= 32'h0;
    end else begin
      wbs_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (is_core) begin
              cur_idx  <= adr_idx;
              req_addr <= wbs_adr_i;
              m_adr_o  <= wbs_adr_i[SLOT_BITS-1:0];
              m_we_o   <= wbs_we_i;
              m_sel_o  <= wbs_sel_i;
              m_dat_o  <= wbs_dat_i;
              strobe   <= NUM_SLAVES'(1) << adr_idx;
              timer    <= 16'h0;
            end else begin
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= is_status ? status_rdata : ERR_DATA;
              if (status_clear) begin
                timeout_cnt  <= 16'h0;
                last_to_addr <= 32'h0;
              end
            end
          end
        end
        ACCESS: begin
          if (!wbs_cyc_i) begin
            strobe <= '0;
          end else if (slave_ack) begin
            strobe    <= '0;
            wbs_dat_o <= slave_dat;
            wbs_ack_o <= 1'b1;
          end else if (timer == TO_LAST) begin
            strobe       <= '0;
            wbs_dat_o    <= ERR_DATA;
            wbs_ack_o    <= 1'b1;
            last_to_addr <= req_addr;
            if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'h1;
          end else begin
            timer <= timer + 16'h1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_slot_interconnect.sv
// Self-checking bench for wb_slot_interconnect: scoreboarded host transactions against
// per-slot slave models with programmable ack delay and stray-ack injection.
`default_nettype none

module tb_wb_slot_interconnect;
  localparam int NS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cyc, stb, we;
  logic [3:0]        sel;
  logic [31:0]       adr, wdat;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [NS-1:0]     m_cyc_o, m_stb_o;
  logic              m_we_o;
  logic [3:0]        m_sel_o;
  logic [31:0]       m_dat_o;
  logic [11:0]       m_adr_o;
  logic [32*NS-1:0]  m_dat_i;
  logic [NS-1:0]     m_ack_i;

  int                checks = 0;
  int                errors = 0;
  logic [31:0]       exp_q[$];

  int                scnt[NS];
  int                sdelay[NS];
  logic [31:0]       sdata[NS];
  logic [NS-1:0]     noise;

  logic [NS-1:0]     snap_stb, snap_cyc;
  logic [11:0]       snap_adr;
  logic [31:0]       snap_dat;
  logic [3:0]        snap_sel;
  logic              snap_we;
  int                ack_seen;

  wb_slot_interconnect dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .m_cyc_o  (m_cyc_o),
    .m_stb_o  (m_stb_o),
    .m_we_o   (m_we_o),
    .m_sel_o  (m_sel_o),
    .m_dat_o  (m_dat_o),
    .m_adr_o  (m_adr_o),
    .m_dat_i  (m_dat_i),
    .m_ack_i  (m_ack_i)
  );

  always #5 clk = ~clk;

  // Slave k acks exactly once, sdelay[k] cycles into its strobe (0 = never); noise forces stray acks.
  always @(negedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (m_stb_o[k]) scnt[k] = scnt[k] + 1;
      else            scnt[k] = 0;
      m_ack_i[k] = ((sdelay[k] > 0) && (scnt[k] == sdelay[k])) || noise[k];
      m_dat_i[32*k +: 32] = sdata[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                      input logic [3:0] s, input logic [31:0] d,
                      input logic chk_data, input logic [31:0] exp_d, input int exp_lat);
    int          lat;
    logic [31:0] exp_pop;
    lat = 0;
    @(negedge clk);
    adr = a; we = w; sel = s; wdat = d; cyc = 1'b1; stb = 1'b1;
    exp_q.push_back(exp_d);
    while (lat <= 1000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        snap_stb = m_stb_o; snap_cyc = m_cyc_o; snap_adr = m_adr_o;
        snap_dat = m_dat_o; snap_sel = m_sel_o; snap_we = m_we_o;
      end
      if (wbs_ack_o) break;
    end
    exp_pop = exp_q.pop_front();
    check({tag, "_ack"}, {31'b0, wbs_ack_o}, 32'd1);
    if (chk_data) check({tag, "_data"}, wbs_dat_o, exp_pop);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, wbs_ack_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    noise = '0;
    for (int k = 0; k < NS; k++) begin
      scnt[k] = 0; sdelay[k] = 0; sdata[k] = 32'h1111_0000 * (k + 1);
    end
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
    check("rst_stb", {28'b0, m_stb_o}, 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    rst = 1'b0;

    // Slot 2 read, slave acks 3 cycles in.
    sdelay[2] = 3; sdata[2] = 32'h1234_5678;
    xfer("rd_slot2", 32'h3000_2010, 1'b0, 4'hF, 32'h0, 1'b1, 32'h1234_5678, 4);
    check("rd_slot2_stb", {28'b0, snap_stb}, 32'h4);
    check("rd_slot2_cyc", {28'b0, snap_cyc}, 32'h4);
    check("rd_slot2_adr", {20'b0, snap_adr}, 32'h010);

    // Slot 0 write, slave acks immediately.
    sdelay[0] = 1;
    xfer("wr_slot0", 32'h3000_0004, 1'b1, 4'b0011, 32'hA5A5_0001, 1'b0, 32'h0, 2);
    check("wr_slot0_stb", {28'b0, snap_stb}, 32'h1);
    check("wr_slot0_dat", snap_dat, 32'hA5A5_0001);
    check("wr_slot0_sel", {28'b0, snap_sel}, 32'h3);
    check("wr_slot0_we",  {31'b0, snap_we}, 32'h1);
    check("wr_slot0_adr", {20'b0, snap_adr}, 32'h004);

    // Slot 1 never acks; a stray ack on unselected slot 3 must be ignored.
    sdelay[1] = 0; noise = 4'b1000;
    xfer("timeout", 32'h3000_1000, 1'b0, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, 256);
    noise = '0;
    xfer("st_cnt1", 32'h3000_4000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h1, 1);
    xfer("st_addr", 32'h3000_4004, 1'b0, 4'hF, 32'h0, 1'b1, 32'h3000_1000, 1);

    // Decode errors.
    xfer("dec_idx6", 32'h3000_6000, 1'b0, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, 1);
    check("dec_idx6_stb", {28'b0, snap_stb}, 32'h0);
    xfer("dec_pfx", 32'h3100_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, 1);
    check("dec_pfx_stb", {28'b0, snap_stb}, 32'h0);

    // Clear status, then confirm.
    xfer("st_clr", 32'h3000_4008, 1'b1, 4'b0001, 32'h1, 1'b0, 32'h0, 1);
    xfer("st_cnt0", 32'h3000_4000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1);
    xfer("st_addr0", 32'h3000_4004, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1);

    // Ack on the same edge as the timeout: data wins, no count.
    sdelay[1] = 255; sdata[1] = 32'hC0DE_0255;
    xfer("ack_vs_to", 32'h3000_1000, 1'b0, 4'hF, 32'h0, 1'b1, 32'hC0DE_0255, 256);
    xfer("st_cnt_tie", 32'h3000_4000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1);

    // Host abandons slot 3 mid-access; a late ack must not reach the host.
    sdelay[3] = 0;
    @(negedge clk);
    adr = 32'h3000_3000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    repeat (3) @(negedge clk);
    check("drop_stb_on", {28'b0, m_stb_o}, 32'h8);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("drop_stb_off", {28'b0, m_stb_o}, 32'h0);
    noise = 4'b1000;
    @(negedge clk);
    noise = '0;
    ack_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (wbs_ack_o) ack_seen++;
    end
    check("drop_no_ack", 32'(ack_seen), 32'd0);
    sdata[0] = 32'h55AA_0000;
    xfer("after_drop", 32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h55AA_0000, 2);

    // Reset mid-access drops strobes asynchronously.
    sdelay[1] = 0;
    @(negedge clk);
    adr = 32'h3000_1ABC; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_on", {28'b0, m_stb_o}, 32'h2);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_stb", {28'b0, m_stb_o}, 32'h0);
    check("rst_mid_cyc", {28'b0, m_cyc_o}, 32'h0);
    check("rst_mid_adr", {20'b0, m_adr_o}, 32'h0);
    check("rst_mid_out", {m_dat_o[30:0], wbs_ack_o}, 32'h0);
    check("rst_mid_dat", wbs_dat_o, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sdelay[0] = 2; sdata[0] = 32'hCAFE_0000;
    xfer("after_rst", 32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 32'hCAFE_0000, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
